// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues credit-limited in-order reads to a
// variable-latency instruction memory and buffers returned words for decode.
module fetch_queue #(
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    INSTR_WIDTH   = 32,
  parameter int                    DEPTH         = 4,
  parameter logic [DATA_WIDTH-1:0] PC_START_ADDR = 64'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   imem_req_o,
  output logic [DATA_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0]  pc_o,
  output logic [DATA_WIDTH-1:0]  pc_4_o,
  input  logic                   redirect_i,
  input  logic [DATA_WIDTH-1:0]  redirect_pc_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  localparam logic [DATA_WIDTH-1:0] C_PC_STEP  = DATA_WIDTH'(3'd4);
  localparam logic [CW-1:0]         C_CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0]         C_CNT_ONE  = CW'(1'b1);
  localparam logic [SW-1:0]         C_CREDIT   = SW'(DEPTH);
  localparam logic [PW-1:0]         C_PTR_ZERO = PW'(1'b0);
  localparam logic [PW-1:0]         C_PTR_ONE  = PW'(1'b1);

  logic [DATA_WIDTH-1:0]  r_fetch_pc;
  logic [INSTR_WIDTH-1:0] r_q_instr [DEPTH];
  logic [DATA_WIDTH-1:0]  r_q_pc    [DEPTH];
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_outstanding;
  logic [CW-1:0]          r_discard;
  logic [DATA_WIDTH-1:0]  r_tag_pc  [DEPTH];
  logic [PW-1:0]          r_tag_rd;
  logic [PW-1:0]          r_tag_wr;

  logic                   w_req;
  logic                   w_valid;
  logic                   w_keep;
  logic                   w_push;
  logic                   w_pop;
  logic [SW-1:0]          w_inflight;
  logic [DATA_WIDTH-1:0]  w_tag_pc;

  // Request credit, response classification and head handshake.
  always_comb begin
    w_inflight = SW'(r_count) + SW'(r_outstanding);
    w_req      = 1'b0;
    if (!rst_i && !redirect_i && (w_inflight < C_CREDIT)) begin
      w_req = 1'b1;
    end else begin
      w_req = 1'b0;
    end
    w_valid  = (r_count != C_CNT_ZERO);
    w_keep   = imem_rvalid_i && (r_discard == C_CNT_ZERO);
    w_push   = w_keep && !redirect_i;
    w_pop    = w_valid && ready_i;
    w_tag_pc = r_tag_pc[r_tag_rd];
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign valid_o     = w_valid;
  assign instr_o     = r_q_instr[r_rd_ptr];
  assign pc_o        = r_q_pc[r_rd_ptr];
  assign pc_4_o      = r_q_pc[r_rd_ptr] + C_PC_STEP;

  // Fetch PC: reset vector, redirect target, or step past each issued request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= PC_START_ADDR;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i;
    end else if (w_req) begin
      r_fetch_pc <= r_fetch_pc + C_PC_STEP;
    end
  end

  // PC tag FIFO pointers follow requests and responses, even across redirects.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag_rd <= C_PTR_ZERO;
      r_tag_wr <= C_PTR_ZERO;
    end else begin
      if (w_req) begin
        r_tag_wr <= r_tag_wr + C_PTR_ONE;
      end
      if (imem_rvalid_i) begin
        r_tag_rd <= r_tag_rd + C_PTR_ONE;
      end
    end
  end

  // Tag and queue storage; contents are qualified by pointers and counts.
  always_ff @(posedge clk_i) begin
    if (w_req) begin
      r_tag_pc[r_tag_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata_i;
      r_q_pc[r_wr_ptr]    <= w_tag_pc;
    end
  end

  // On redirect every response still in flight after this cycle is stale.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= C_CNT_ZERO;
      r_discard     <= C_CNT_ZERO;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req) - CW'(imem_rvalid_i);
      if (redirect_i) begin
        r_discard <= r_outstanding - CW'(imem_rvalid_i);
      end else if (imem_rvalid_i && !w_keep) begin
        r_discard <= r_discard - C_CNT_ONE;
      end
    end
  end

  // Decode queue pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      r_rd_ptr <= C_PTR_ZERO;
      r_wr_ptr <= C_PTR_ZERO;
      r_count  <= C_CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (w_push),
    .rvalid_i      (imem_rvalid_i),
    .count_i       (r_count),
    .outstanding_i (r_outstanding)
  );

endmodule

// fetch_queue_chk: structural invariants of the fetch queue credit scheme.
module fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          push_i,
  input logic          rvalid_i,
  input logic [CW-1:0] count_i,
  input logic [CW-1:0] outstanding_i
);

  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW:0]   C_CAP  = (CW + 1)'(DEPTH);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && (count_i == C_FULL)));

  a_credit_cap: assert property (@(posedge clk_i) disable iff (rst_i)
    ({1'b0, count_i} + {1'b0, outstanding_i}) <= C_CAP);

  a_resp_tracked: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rvalid_i && (outstanding_i == CW'(1'b0))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: fetch_queue against a queue-level behavioural model, an
// architectural PC-sequence scoreboard and hand-computed directed expectations.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [63:0] START = 64'h100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic [63:0] pc_4_o;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'h0;

  fetch_queue #(
    .DATA_WIDTH    (64),
    .INSTR_WIDTH   (32),
    .DEPTH         (DEPTH),
    .PC_START_ADDR (START)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_4_o        (pc_4_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; bit stale; } inf_t;
  typedef struct { logic [63:0] addr; int due; } pend_t;

  int n_cmp = 0;
  int n_fail = 0;

  // stimulus knobs for the next cycle
  logic        t_rst = 1'b1, t_ready = 1'b0, t_redir = 1'b0;
  logic [63:0] t_rpc = 64'h0;
  int          t_lat = 1;
  bit          t_lat_rand = 1'b0;

  // bookkeeping
  int          cyc = 0, k = 0, last_due = 0, req_cnt = 0, first_valid_k = -1;
  bit          started = 1'b0, have_req = 1'b0;
  logic [63:0] first_req_addr = 64'h0, arch_next = START;
  logic [63:0] dlv [$];

  // behavioural model and memory
  logic [63:0] m_q [$];
  inf_t        m_inf [$];
  logic [63:0] m_fetch = START;
  pend_t       pend [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dget(input int i);
    if (i < dlv.size()) return dlv[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic step();
    logic        exp_req;
    logic        rv;
    logic [63:0] sh;
    int          lat;
    int          due;
    inf_t        e;
    @(negedge clk);
    if (started) begin
      chk("valid", 64'(valid_o), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        sh = m_q[0] >> 2;
        chk("pc", pc_o, m_q[0]);
        chk("pc_4", pc_4_o, m_q[0] + 64'd4);
        chk("instr", 64'(instr_o), {32'h0, sh[31:0]});
      end
    end
    rst_i         = t_rst;
    ready_i       = t_ready;
    redirect_i    = t_redir;
    redirect_pc_i = t_rpc;
    rv = 1'b0;
    if (t_rst) begin
      pend.delete();
      last_due = cyc;
    end else if (pend.size() != 0 && pend[0].due == cyc) begin
      rv = 1'b1;
      sh = pend[0].addr >> 2;
      imem_rdata_i = sh[31:0];
      void'(pend.pop_front());
    end
    imem_rvalid_i = rv;
    if (!rv) imem_rdata_i = 32'h0;
    #1;
    exp_req = !t_rst && !t_redir && (m_q.size() + m_inf.size() < DEPTH);
    chk("req", 64'(imem_req_o), 64'(exp_req));
    if (exp_req && imem_req_o) chk("addr", imem_addr_o, m_fetch);
    if (imem_req_o) begin
      req_cnt++;
      if (!have_req) begin
        have_req = 1'b1;
        first_req_addr = imem_addr_o;
      end
      lat = t_lat_rand ? int'($urandom_range(1, 5)) : t_lat;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: imem_addr_o, due: due});
    end
    if (started && !t_rst) begin
      if (valid_o && first_valid_k < 0) first_valid_k = k;
      if (valid_o && ready_i) begin
        dlv.push_back(pc_o);
        chk("arch_seq", pc_o, arch_next);
        arch_next = pc_o + 64'd4;
      end
      if (t_redir) arch_next = t_rpc;
    end
    // model transition for this clock edge
    if (t_rst) begin
      m_q.delete();
      m_inf.delete();
      m_fetch = START;
      arch_next = START;
      dlv.delete();
      req_cnt = 0;
      first_valid_k = -1;
      have_req = 1'b0;
    end else begin
      if (m_q.size() != 0 && t_ready) void'(m_q.pop_front());
      if (rv && m_inf.size() != 0) begin
        e = m_inf.pop_front();
        if (!e.stale && !t_redir) m_q.push_back(e.pc);
      end
      if (t_redir) begin
        m_q.delete();
        foreach (m_inf[i]) m_inf[i].stale = 1'b1;
        m_fetch = t_rpc;
      end else if (exp_req) begin
        m_inf.push_back('{pc: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 64'd4;
      end
    end
    if (t_rst) started = 1'b1;
    cyc++;
    k = t_rst ? 0 : k + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    t_rst = 1'b1;
    t_redir = 1'b0;
    run(2);
    t_rst = 1'b0;
  endtask

  initial begin
    // reset and stream, 1-cycle memory
    t_lat = 1;
    do_reset();
    chk("rst_valid", 64'(valid_o), 64'd0);
    t_ready = 1'b1;
    run(10);
    chk("s_first_req", first_req_addr, 64'h100);
    chk("s_first_valid_k", 64'(first_valid_k), 64'd2);
    chk("s_count", 64'(dlv.size()), 64'd8);
    chk("s_d0", dget(0), 64'h100);
    chk("s_d1", dget(1), 64'h104);
    chk("s_d7", dget(7), 64'h11C);

    // backpressure
    do_reset();
    t_ready = 1'b0;
    run(8);
    chk("bp_reqs", 64'(req_cnt), 64'd4);
    chk("bp_none", 64'(dlv.size()), 64'd0);
    t_ready = 1'b1;
    run(8);
    chk("bp_dcount", 64'(dlv.size()), 64'd8);
    chk("bp_d0", dget(0), 64'h100);
    chk("bp_d3", dget(3), 64'h10C);
    chk("bp_d4", dget(4), 64'h110);
    chk("bp_reqs_total", 64'(req_cnt), 64'd11);

    // redirect with two words in flight, 3-cycle memory
    t_lat = 3;
    do_reset();
    t_ready = 1'b1;
    run(2);
    t_redir = 1'b1;
    t_rpc = 64'h2000;
    run(1);
    t_redir = 1'b0;
    run(8);
    chk("rd_first_valid_k", 64'(first_valid_k), 64'd7);
    chk("rd_count", 64'(dlv.size()), 64'd4);
    chk("rd_d0", dget(0), 64'h2000);
    chk("rd_d1", dget(1), 64'h2004);

    // redirect with handshake in the same cycle
    t_lat = 1;
    do_reset();
    t_ready = 1'b1;
    run(4);
    t_redir = 1'b1;
    t_rpc = 64'h3000;
    run(1);
    t_redir = 1'b0;
    run(5);
    chk("hs_count", 64'(dlv.size()), 64'd6);
    chk("hs_d2", dget(2), 64'h108);
    chk("hs_d3", dget(3), 64'h3000);
    chk("hs_d4", dget(4), 64'h3004);

    // redirect near the top of the address space: PC wraps to zero
    do_reset();
    t_ready = 1'b1;
    run(2);
    t_redir = 1'b1;
    t_rpc = 64'hFFFF_FFFF_FFFF_FFF8;
    run(1);
    t_redir = 1'b0;
    run(8);
    chk("wr_count", 64'(dlv.size()), 64'd7);
    chk("wr_d1", dget(1), 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wr_d3", dget(3), 64'h0);

    // random latency, random ready, sparse redirects
    t_lat_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      t_ready = ($urandom_range(0, 3) != 0);
      t_redir = ($urandom_range(0, 24) == 0);
      t_rpc = 64'($urandom_range(0, 16'hFFFF)) << 2;
      run(1);
    end
    t_redir = 1'b0;
    t_lat_rand = 1'b0;

    // mid-stream reset with a full queue
    t_lat = 1;
    do_reset();
    t_ready = 1'b0;
    run(8);
    chk("mr_full_valid", 64'(valid_o), 64'd1);
    t_rst = 1'b1;
    run(1);
    t_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_valid_after_rst", 64'(valid_o), 64'd0);
    run(3);
    chk("mr_first_req", first_req_addr, START);
    chk("mr_reqs", 64'(req_cnt), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
